// File: rtl/queue_reader_16_8.sv
// Queue drain: pops 16-bit words and serializes each into two bytes on a valid/ready stream.
// Byte order is big-endian unless QUEUE_READER_LOW_FIRST_EN is defined (then low byte first).
module queue_reader_16_8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        q_empty,
  output logic        q_pop,
  input  logic [15:0] q_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] word_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] B0   = 2'd1;
  localparam logic [1:0] B1   = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [15:0] cur_r;
  logic [15:0] nxt_r;
  logic        nxt_valid_r;
  logic        pop_d_r;
  logic [15:0] word_count_r;
  logic        pop_s;
  logic        load_s;
  logic        word_done_s;
  logic        tx_valid_s;
  logic [7:0]  tx_data_s;
  logic [7:0]  first_byte_s;
  logic [7:0]  second_byte_s;

  // Spacing pops by one cycle keeps the queue's lagging empty flag from causing an over-read.
  assign pop_s = enable & ~q_empty & ~pop_d_r & ~nxt_valid_r & ~reset;

`ifdef QUEUE_READER_LOW_FIRST_EN
  assign first_byte_s  = cur_r[7:0];
  assign second_byte_s = cur_r[15:8];
`else
  assign first_byte_s  = cur_r[15:8];
  assign second_byte_s = cur_r[7:0];
`endif

  // Next state, prefetch hand-off and byte presentation.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    word_done_s = 1'b0;
    tx_valid_s  = 1'b0;
    tx_data_s   = 8'h00;
    case (state_r)
      IDLE: begin
        if (nxt_valid_r) begin
          load_s      = 1'b1;
          state_nxt_s = B0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      B0: begin
        tx_valid_s = 1'b1;
        tx_data_s  = first_byte_s;
        if (tx_ready) begin
          state_nxt_s = B1;
        end else begin
          state_nxt_s = B0;
        end
      end
      B1: begin
        tx_valid_s = 1'b1;
        tx_data_s  = second_byte_s;
        if (tx_ready) begin
          word_done_s = 1'b1;
          if (nxt_valid_r) begin
            load_s      = 1'b1;
            state_nxt_s = B0;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = B1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, word registers and sent-word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cur_r        <= 16'h0000;
      nxt_r        <= 16'h0000;
      nxt_valid_r  <= 1'b0;
      pop_d_r      <= 1'b0;
      word_count_r <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      pop_d_r <= pop_s;
      if (load_s) begin
        cur_r <= nxt_r;
      end
      // A pop needs an empty slot, so it never coincides with a load out of nxt.
      if (pop_s) begin
        nxt_r       <= q_dout;
        nxt_valid_r <= 1'b1;
      end else if (load_s) begin
        nxt_valid_r <= 1'b0;
      end
      if (word_done_s) begin
        word_count_r <= word_count_r + 16'd1;
      end
    end
  end

  assign q_pop      = pop_s;
  assign tx_valid   = tx_valid_s;
  assign tx_data    = tx_data_s;
  assign busy       = (state_r != IDLE) | nxt_valid_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_queue_reader_16_8.sv
// Randomized self-checking bench for queue_reader_16_8: a queue model feeds the DUT and a byte
// scoreboard (built from popped words) checks every accepted byte and the word counter.
module tb_queue_reader_16_8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        q_empty = 1'b1;
  logic [15:0] q_dout = 16'h0000;
  logic        tx_ready = 1'b0;
  logic        q_pop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [15:0] word_count;

  int checks = 0;
  int failures = 0;

  logic [15:0] tbq[$];
  logic [7:0]  exp_bytes[$];
  int          bytes_sent = 0;
  logic        prev_pop = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        pop_seen = 1'b0;

  queue_reader_16_8 dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .q_empty    (q_empty),
    .q_pop      (q_pop),
    .q_dout     (q_dout),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_first(input logic [15:0] w);
`ifdef QUEUE_READER_LOW_FIRST_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  function automatic logic [7:0] byte_second(input logic [15:0] w);
`ifdef QUEUE_READER_LOW_FIRST_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  // Scoreboard: pop legality, byte order/content, hold under back-pressure, word counter.
  always @(negedge clk) begin
    pop_seen = (q_pop === 1'b1);
    if (reset) begin
      checks++;
      if (q_pop !== 1'b0) begin
        failures++;
        $display("FAIL pop_in_reset: q_pop=%b required 0", q_pop);
      end
      exp_bytes.delete();
      bytes_sent = 0;
      prev_pop = 1'b0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (word_count !== 16'(bytes_sent / 2)) begin
        failures++;
        $display("FAIL word_count: got %0d required %0d", word_count, bytes_sent / 2);
      end
      if (q_pop === 1'b1) begin
        checks++;
        if (prev_pop || q_empty || !enable) begin
          failures++;
          $display("FAIL pop_rule: q_pop=1 prev_pop=%b q_empty=%b enable=%b required no pop",
                   prev_pop, q_empty, enable);
        end
        exp_bytes.push_back(byte_first(q_dout));
        exp_bytes.push_back(byte_second(q_dout));
      end
      if (prev_stall) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h",
                   tx_valid, tx_data, prev_data);
        end
      end
      if (tx_valid !== 1'b1) begin
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
          failures++;
          $display("FAIL idle_out: valid=%b data=%h required valid=0 data=00", tx_valid, tx_data);
        end
      end else if (tx_ready) begin
        checks++;
        if (exp_bytes.size() == 0) begin
          failures++;
          $display("FAIL byte_extra: got %h required no byte", tx_data);
        end else begin
          if (tx_data !== exp_bytes[0]) begin
            failures++;
            $display("FAIL byte_value: got %h required %h", tx_data, exp_bytes[0]);
          end
          void'(exp_bytes.pop_front());
        end
        bytes_sent++;
      end
      prev_pop = (q_pop === 1'b1);
      prev_stall = (tx_valid === 1'b1) && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic drive_q();
    q_empty = (tbq.size() == 0);
    q_dout = (tbq.size() == 0) ? 16'h0000 : tbq[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_seen) void'(tbq.pop_front());
    drive_q();
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    enable = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tbq.size() == 0 && busy === 1'b0 && tx_valid === 1'b0) done = 1'b1;
      tick();
      if (done) break;
    end
    checks++;
    if (!done || exp_bytes.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: done=%0d pending_bytes=%0d required done=1 pending=0",
               name, done, exp_bytes.size());
    end
  endtask

  // Returns aligned just after the edge that ended the first accepted byte.
  task automatic wait_first_accept(input string name, output int pops);
    bit seen = 1'b0;
    pops = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (q_pop === 1'b1) pops++;
      if (tx_valid === 1'b1 && tx_ready) seen = 1'b1;
      tick();
      if (seen) break;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: no byte accepted, required one", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    tx_ready = 1'b1;
    drive_q();
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks += 5;
    if (q_pop !== 1'b0) begin failures++; $display("FAIL rst_q_pop: got %b required 0", q_pop); end
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid: got %b required 0", tx_valid); end
    if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (word_count !== 16'h0000) begin failures++; $display("FAIL rst_word_count: got %h required 0000", word_count); end
    tick();
  endtask

  task automatic test_single_word();
    int pop_cyc = -1;
    int b0_cyc = -1;
    int b1_cyc = -1;
    int pops = 0;
    logic [7:0] b0 = 8'h00;
    logic [7:0] b1 = 8'h00;
    logic [15:0] w = 16'hA55A;
    tbq.push_back(w);
    drive_q();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (q_pop === 1'b1) begin pops++; pop_cyc = i; end
      if (tx_valid === 1'b1 && tx_ready) begin
        if (b0_cyc < 0) begin b0_cyc = i; b0 = tx_data; end
        else if (b1_cyc < 0) begin b1_cyc = i; b1 = tx_data; end
      end
      tick();
    end
    checks += 5;
    if (pops != 1) begin failures++; $display("FAIL single_pops: got %0d required 1", pops); end
    if (b0_cyc != pop_cyc + 2) begin failures++; $display("FAIL single_latency: first byte cycle %0d required %0d", b0_cyc, pop_cyc + 2); end
    if (b1_cyc != b0_cyc + 1) begin failures++; $display("FAIL single_gap: second byte cycle %0d required %0d", b1_cyc, b0_cyc + 1); end
    if (b0 !== byte_first(w) || b1 !== byte_second(w)) begin
      failures++;
      $display("FAIL single_bytes: got %h %h required %h %h", b0, b1, byte_first(w), byte_second(w));
    end
    @(negedge clk);
    if (word_count !== 16'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_end: word_count=%0d busy=%b required 1 and 0", word_count, busy);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [15:0] words[3] = '{16'h0102, 16'h0304, 16'h0506};
    logic [7:0]  got[$];
    int          cyc[$];
    int          pops = 0;
    bit          ok = 1'b1;
    for (int k = 0; k < 3; k++) tbq.push_back(words[k]);
    drive_q();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (q_pop === 1'b1) pops++;
      if (tx_valid === 1'b1 && tx_ready) begin got.push_back(tx_data); cyc.push_back(i); end
      tick();
    end
    checks += 3;
    if (got.size() != 6) ok = 1'b0;
    for (int k = 0; k < got.size() && k < 6; k++) begin
      if (got[k] !== ((k % 2 == 0) ? byte_first(words[k / 2]) : byte_second(words[k / 2]))) ok = 1'b0;
      if (k > 0 && cyc[k] != cyc[k - 1] + 1) ok = 1'b0;
    end
    if (!ok) begin failures++; $display("FAIL stream_bytes: got %0d bytes %p required 6 consecutive in order", got.size(), got); end
    if (pops != 3) begin failures++; $display("FAIL stream_pops: got %0d required 3", pops); end
    if (word_count !== 16'd4) begin failures++; $display("FAIL stream_count: got %0d required 4", word_count); end
  endtask

  task automatic test_backpressure();
    int pops;
    logic [15:0] w1 = 16'h1122;
    tbq.push_back(w1);
    tbq.push_back(16'h3344);
    tbq.push_back(16'h5566);
    drive_q();
    wait_first_accept("bp", pops);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (q_pop === 1'b1) pops++;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== byte_second(w1)) begin
        failures++;
        $display("FAIL bp_hold: valid=%b data=%h required 1 %h", tx_valid, tx_data, byte_second(w1));
      end
      tick();
    end
    checks++;
    if (pops != 2) begin failures++; $display("FAIL bp_prefetch: pops=%0d required 2", pops); end
    drain("bp");
    checks++;
    if (word_count !== 16'd7) begin failures++; $display("FAIL bp_count: got %0d required 7", word_count); end
  endtask

  task automatic test_empty_enable();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (q_pop !== 1'b0 || tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL empty_gate: q_pop=%b tx_valid=%b required 0 0", q_pop, tx_valid);
      end
      tick();
    end
    enable = 1'b0;
    tbq.push_back(16'hBEEF);
    tbq.push_back(16'h00FF);
    drive_q();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (q_pop !== 1'b0) begin failures++; $display("FAIL enable_gate: q_pop=%b required 0", q_pop); end
      tick();
    end
    drain("en");
    checks++;
    if (word_count !== 16'd9) begin failures++; $display("FAIL en_count: got %0d required 9", word_count); end
  endtask

  task automatic test_reset_midway();
    int pops;
    tbq.push_back(16'h1357);
    tbq.push_back(16'h2468);
    tbq.push_back(16'h9ABC);
    drive_q();
    wait_first_accept("mid", pops);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup: busy=%b tx_valid=%b required 1 1", busy, tx_valid);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || word_count !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset: tx_valid=%b busy=%b word_count=%0d required 0 0 0", tx_valid, busy, word_count);
    end
    if (q_pop !== 1'b1 || q_dout !== 16'h9ABC) begin
      failures++;
      $display("FAIL mid_fresh: q_pop=%b q_dout=%h required 1 9abc", q_pop, q_dout);
    end
    tick();
    drain("mid");
    checks++;
    if (word_count !== 16'd1) begin failures++; $display("FAIL mid_count: got %0d required 1", word_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (tbq.size() < 6 && $urandom_range(0, 2) == 0) tbq.push_back(16'($urandom()));
      drive_q();
      tx_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      tick();
    end
    drain("rand");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stream();
    test_backpressure();
    test_empty_enable();
    test_reset_midway();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
